shift_collector: RTL and testbench

- Downstream deserializer for the chunk stream produced by the word shift register.
- Collects NUM_CHUNKS chunks of SHIFT_WIDTH bits, least-significant chunk first, into one PADDED_WIDTH accumulator.
- Strips the left zero padding and presents one WORD_SIZE word over a valid/ready handshake.
- Sits between the serial datapath output and the word-wide output interface of the Ascon core.

---
 rtl/shift_collector_pkg.sv | 10 +
 rtl/shift_collector_if.sv | 24 ++
 rtl/shift_collector.sv | 90 +++++++++
 tb/tb_shift_collector.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/shift_collector_pkg.sv
// Shared sizing for the chunk collector: word/chunk widths and derived counts.
package shift_collector_pkg;
  localparam int WORD_SIZE    = 64;
  localparam int SHIFT_WIDTH  = 24;
  localparam int NUM_CHUNKS   = (WORD_SIZE + SHIFT_WIDTH - 1) / SHIFT_WIDTH;
  localparam int PADDED_WIDTH = NUM_CHUNKS * SHIFT_WIDTH;
  localparam int CNT_W        = $clog2(NUM_CHUNKS + 1);

  typedef enum logic {COLLECT, FULL} collect_state_t;
endpackage

// File: rtl/shift_collector_if.sv
// Chunk-in / word-out handshake bundle between the serial datapath and the word consumer.
interface shift_collector_if;
  import shift_collector_pkg::*;

  logic                   clear;
  logic                   in_valid;
  logic                   in_ready;
  logic [SHIFT_WIDTH-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [WORD_SIZE-1:0]   out_data;
  logic                   pad_err;
  logic [CNT_W-1:0]       chunk_cnt;

  modport master (
    output clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, pad_err, chunk_cnt
  );

  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, pad_err, chunk_cnt
  );
endinterface

// File: rtl/shift_collector.sv
// Reassembles LSB-first chunks into one word, strips the zero padding and flags non-zero padding.
module shift_collector
  import shift_collector_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  shift_collector_if.slave bus
);

  collect_state_t          r_state, w_state_nxt;
  logic [PADDED_WIDTH-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_handshake;
  logic                    w_pad_nz;

  assign w_in_ready  = (r_state == COLLECT) ? 1'b1 : bus.out_ready;
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_handshake = (r_state == FULL) & bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= COLLECT;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    if (bus.clear) begin
      w_state_nxt = COLLECT;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      // New chunks enter at the top so the first one ends up in the low bits.
      if (w_accept)
        w_acc_nxt = {bus.in_data, r_acc[PADDED_WIDTH-1:SHIFT_WIDTH]};
      unique case (r_state)
        COLLECT: begin
          if (w_accept) begin
            if (r_cnt == CNT_W'(NUM_CHUNKS - 1)) begin
              w_state_nxt = FULL;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
          end
        end
        FULL: begin
          if (w_handshake) begin
            if (w_accept && (NUM_CHUNKS == 1)) begin
              w_state_nxt = FULL;
              w_cnt_nxt   = '0;
            end else if (w_accept) begin
              w_state_nxt = COLLECT;
              w_cnt_nxt   = CNT_W'(1);
            end else begin
              w_state_nxt = COLLECT;
              w_cnt_nxt   = '0;
            end
          end
        end
        default: w_state_nxt = COLLECT;
      endcase
    end
  end

  generate
    if (WORD_SIZE == PADDED_WIDTH) begin : g_no_pad
      assign w_pad_nz = 1'b0;
    end else begin : g_pad
      assign w_pad_nz = |r_acc[PADDED_WIDTH-1:WORD_SIZE];
    end
  endgenerate

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == FULL);
  assign bus.out_data  = r_acc[WORD_SIZE-1:0];
  assign bus.pad_err   = (r_state == FULL) & w_pad_nz;
  assign bus.chunk_cnt = r_cnt;

endmodule

// File: tb/tb_shift_collector.sv
// Randomized and directed bench for shift_collector against a queue-based word model.
module tb_shift_collector;
  import shift_collector_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  shift_collector_if bus();

  shift_collector dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: chunks of the word in progress and one pending word.
  logic [SHIFT_WIDTH-1:0]  m_q[$];
  logic                    m_pend = 1'b0;
  logic [PADDED_WIDTH-1:0] m_word = '0;

  task automatic chk(input string nm, input logic [PADDED_WIDTH-1:0] act,
                     input logic [PADDED_WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge reset_n) begin
    m_q.delete();
    m_pend = 1'b0;
  end

  always @(posedge clk) begin
    if (reset_n) begin
      if (bus.clear) begin
        m_q.delete();
        m_pend = 1'b0;
      end else begin
        logic acc, hs;
        acc = bus.in_valid && (!m_pend || bus.out_ready);
        hs  = m_pend && bus.out_ready;
        if (hs) m_pend = 1'b0;
        if (acc) begin
          m_q.push_back(bus.in_data);
          if (m_q.size() == NUM_CHUNKS) begin
            m_word = '0;
            for (int i = 0; i < NUM_CHUNKS; i++)
              m_word[i*SHIFT_WIDTH +: SHIFT_WIDTH] = m_q[i];
            m_pend = 1'b1;
            m_q.delete();
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("out_valid", PADDED_WIDTH'(bus.out_valid), PADDED_WIDTH'(m_pend));
      chk("in_ready", PADDED_WIDTH'(bus.in_ready), PADDED_WIDTH'(!m_pend || bus.out_ready));
      chk("chunk_cnt", PADDED_WIDTH'(bus.chunk_cnt), PADDED_WIDTH'(m_q.size()));
      if (m_pend) begin
        chk("out_data", PADDED_WIDTH'(bus.out_data), PADDED_WIDTH'(m_word[WORD_SIZE-1:0]));
        chk("pad_err", PADDED_WIDTH'(bus.pad_err),
            PADDED_WIDTH'(|m_word[PADDED_WIDTH-1:WORD_SIZE]));
      end
    end
  end

  task automatic step(input logic v, input logic [SHIFT_WIDTH-1:0] d,
                      input logic ordy, input logic clr);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.clear     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_out_valid"}, PADDED_WIDTH'(bus.out_valid), '0);
    chk({nm, "_out_data"},  PADDED_WIDTH'(bus.out_data),  '0);
    chk({nm, "_pad_err"},   PADDED_WIDTH'(bus.pad_err),   '0);
    chk({nm, "_chunk_cnt"}, PADDED_WIDTH'(bus.chunk_cnt), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_words;
    bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    #22;
    chk_zero_outputs("reset");
    chk("reset_in_ready", PADDED_WIDTH'(bus.in_ready), 1);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Single word, clean padding.
    step(1, 24'h123456, 1, 0);
    step(1, 24'h9ABCDE, 1, 0);
    chk("single_not_yet", PADDED_WIDTH'(bus.out_valid), 0);
    step(1, 24'h000011, 1, 0);
    chk("single_valid", PADDED_WIDTH'(bus.out_valid), 1);
    chk("single_data", PADDED_WIDTH'(bus.out_data), 72'h00_00119ABCDE123456);
    chk("single_pad", PADDED_WIDTH'(bus.pad_err), 0);
    step(0, 0, 1, 0);
    chk("single_consumed", PADDED_WIDTH'(bus.out_valid), 0);

    // Non-zero padding.
    step(1, 24'h123456, 1, 0);
    step(1, 24'h9ABCDE, 1, 0);
    step(1, 24'hFF0011, 0, 0);
    chk("pad_data", PADDED_WIDTH'(bus.out_data), 72'h00_00119ABCDE123456);
    chk("pad_flag", PADDED_WIDTH'(bus.pad_err), 1);
    step(0, 0, 1, 0);

    // Backpressure, then hand-off with a same-cycle chunk.
    step(1, 24'hA00001, 0, 0);
    step(1, 24'hA00002, 0, 0);
    step(1, 24'h0000A3, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 24'hBEEF00 + 24'(i), 0, 0);
      chk("bp_in_ready", PADDED_WIDTH'(bus.in_ready), 0);
      chk("bp_data", PADDED_WIDTH'(bus.out_data), 72'h00_0000A3A00002A00001);
    end
    step(1, 24'h000C01, 1, 0);
    chk("handoff_cnt", PADDED_WIDTH'(bus.chunk_cnt), 1);
    chk("handoff_valid", PADDED_WIDTH'(bus.out_valid), 0);
    step(1, 24'h000C02, 1, 0);
    step(1, 24'h000C03, 1, 0);
    chk("handoff_word", PADDED_WIDTH'(bus.out_data), 72'h00_000C03000C02000C01);
    step(0, 0, 1, 0);

    // Streaming: 4 words back to back.
    n_words = 0;
    for (int i = 0; i < 4 * NUM_CHUNKS; i++) begin
      step(1, 24'($urandom) & 24'h00FFFF, 1, 0);
      if (bus.out_valid) n_words++;
    end
    chk("stream_words", PADDED_WIDTH'(n_words), 4);
    step(0, 0, 1, 0);

    // clear mid-word discards the partial word and the clear-cycle chunk.
    step(1, 24'h111111, 1, 0);
    step(1, 24'h222222, 1, 0);
    step(1, 24'h333333, 1, 1);
    chk("clear_cnt", PADDED_WIDTH'(bus.chunk_cnt), 0);
    step(1, 24'h000001, 1, 0);
    step(1, 24'h000002, 1, 0);
    step(1, 24'h000003, 1, 0);
    chk("clear_word", PADDED_WIDTH'(bus.out_data), 72'h00_000003000002000001);
    chk("clear_pad", PADDED_WIDTH'(bus.pad_err), 0);
    step(0, 0, 1, 0);

    // Asynchronous reset mid-cycle, partway through a word.
    step(1, 24'h0F0F0F, 1, 0);
    step(1, 24'h0E0E0E, 1, 0);
    #3 reset_n = 1'b0;
    #1 chk_zero_outputs("rst_mid");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Asynchronous reset coincident with an accepting edge.
    step(1, 24'h0A0A0A, 1, 0);
    bus.in_valid = 1'b1; bus.in_data = 24'h0B0B0B;
    @(posedge clk);
    reset_n = 1'b0;
    #1 chk_zero_outputs("rst_edge");
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    step(1, 24'h000AAA, 1, 0);
    step(1, 24'h000BBB, 1, 0);
    step(1, 24'h000CCC, 1, 0);
    chk("post_reset_word", PADDED_WIDTH'(bus.out_data), 72'h00_000CCC000BBB000AAA);
    step(0, 0, 1, 0);

    // Random traffic with occasional flushes and padding faults.
    for (int i = 0; i < 400; i++) begin
      logic [SHIFT_WIDTH-1:0] d;
      d = 24'($urandom);
      if ($urandom_range(0, 3) != 0) d[SHIFT_WIDTH-1:16] = '0;
      step(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 29) == 0));
    end
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
